// File: rtl/adpll_mod_tx_pkg.sv
// Shared definitions for the ADPLL modulation TX source: register map,
// FSM state type and small bit-ordering helpers.
package adpll_mod_tx_pkg;

    localparam int unsigned ADPLL_ADDR_W = 8;

    localparam logic [ADPLL_ADDR_W-1:0] MOD_TX_DATA = 8'h40;
    localparam logic [ADPLL_ADDR_W-1:0] MOD_BIT_DIV = 8'h44;
    localparam logic [ADPLL_ADDR_W-1:0] MOD_CTRL    = 8'h48;
    localparam logic [ADPLL_ADDR_W-1:0] MOD_STATUS  = 8'h4C;

    localparam int unsigned BIT_DIV_RST = 31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_STOP
    } tx_state_e;

    // Bit presented on the line for a given byte image and bit order.
    function automatic logic out_bit(input logic [7:0] v, input logic msb);
        return msb ? v[7] : v[0];
    endfunction

    // Byte image after the presented bit has been consumed.
    function automatic logic [7:0] shift_next(input logic [7:0] v, input logic msb);
        return msb ? {v[6:0], 1'b0} : {1'b0, v[7:1]};
    endfunction

endpackage

// File: rtl/adpll_mod_tx_fifo.sv
// Synchronous byte FIFO, 2**AW deep, with flush. Push while full is
// accepted only when a pop happens in the same cycle.
module adpll_mod_fifo #(
    parameter int unsigned AW = 3,
    parameter int unsigned W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    assign level   = wptr - rptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign rdata   = mem[rptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer update; flush takes priority over any same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage write; no reset needed on the data array.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/adpll_mod_tx.sv
// ADPLL TX bitstream source: CPU-loaded byte FIFO serialised onto data_mod
// at a programmable bit period, back-to-back across bytes.
module adpll_mod_tx
    import adpll_mod_tx_pkg::*;
#(
    parameter int unsigned FIFO_AW = 3,
    parameter int unsigned DIV_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid,
    input  logic [ADPLL_ADDR_W-1:0] address,
    input  logic [31:0]             wdata,
    input  logic                    wstrb,
    output logic [31:0]             rdata,
    output logic                    ready,
    output logic                    data_mod,
    output logic                    tx_busy
);

    logic             en;
    logic             msb_first;
    logic             idle_lvl;
    logic [DIV_W-1:0] bit_div;
    logic             ovf;

    logic             wr;
    logic             push;
    logic             pop;
    logic             flush;

    logic [7:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_level;

    tx_state_e        state;
    logic [7:0]       shreg;
    logic             msb_lat;
    logic [2:0]       bit_cnt;
    logic [DIV_W-1:0] div_cnt;

    logic             unused_bits;

    assign wr      = valid && wstrb;
    assign push    = wr && (address == MOD_TX_DATA);
    assign flush   = wr && (address == MOD_CTRL) && wdata[3];
    assign tx_busy = (state != ST_IDLE);
    assign unused_bits = ^wdata[31:DIV_W];

    adpll_mod_fifo #(
        .AW (FIFO_AW),
        .W  (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wdata[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Pop when idle with data, or at the last clock of bit 7 so the next byte follows with no gap.
    always_comb begin
        pop = 1'b0;
        if (en && !fifo_empty) begin
            if (state == ST_IDLE)
                pop = 1'b1;
            else if (state == ST_SHIFT && div_cnt == '0 && bit_cnt == 3'd7)
                pop = 1'b1;
        end
    end

    // CPU register file: control, divider, sticky overflow and access handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready     <= 1'b0;
            en        <= 1'b0;
            msb_first <= 1'b0;
            idle_lvl  <= 1'b0;
            bit_div   <= DIV_W'(BIT_DIV_RST);
            ovf       <= 1'b0;
        end else begin
            ready <= valid;
            if (wr && address == MOD_BIT_DIV)
                bit_div <= wdata[DIV_W-1:0];
            if (wr && address == MOD_CTRL) begin
                en        <= wdata[0];
                msb_first <= wdata[1];
                idle_lvl  <= wdata[2];
            end
            if (wr && address == MOD_STATUS && wdata[3])
                ovf <= 1'b0;
            if (push && fifo_full && !pop)
                ovf <= 1'b1;
        end
    end

    // Read mux, combinational from address.
    always_comb begin
        rdata = '1;
        case (address)
            MOD_TX_DATA: rdata = '0;
            MOD_BIT_DIV: rdata = 32'(bit_div);
            MOD_CTRL:    rdata = {29'b0, idle_lvl, msb_first, en};
            MOD_STATUS:  rdata = {24'b0, 4'(fifo_level), ovf, fifo_empty, fifo_full, tx_busy};
            default:     rdata = '1;
        endcase
    end

    // Serialiser FSM: divider, bit counter, shift register and registered data_mod.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            data_mod <= 1'b0;
            shreg    <= '0;
            msb_lat  <= 1'b0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        data_mod <= out_bit(fifo_rdata, msb_first);
                        shreg    <= shift_next(fifo_rdata, msb_first);
                        msb_lat  <= msb_first;
                        bit_cnt  <= '0;
                        div_cnt  <= bit_div;
                        state    <= ST_SHIFT;
                    end else begin
                        data_mod <= idle_lvl;
                    end
                end
                ST_SHIFT: begin
                    if (!en) begin
                        data_mod <= idle_lvl;
                        state    <= ST_IDLE;
                    end else if (div_cnt == '0) begin
                        div_cnt <= bit_div;
                        if (bit_cnt == 3'd7) begin
                            if (pop) begin
                                data_mod <= out_bit(fifo_rdata, msb_first);
                                shreg    <= shift_next(fifo_rdata, msb_first);
                                msb_lat  <= msb_first;
                                bit_cnt  <= '0;
                            end else begin
                                data_mod <= idle_lvl;
                                state    <= ST_STOP;
                            end
                        end else begin
                            data_mod <= out_bit(shreg, msb_lat);
                            shreg    <= shift_next(shreg, msb_lat);
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    data_mod <= idle_lvl;
                    if (!en || div_cnt == '0)
                        state <= ST_IDLE;
                    else
                        div_cnt <= div_cnt - 1'b1;
                end
                default: begin
                    data_mod <= idle_lvl;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adpll_mod_tx.sv
// Directed self-checking bench for adpll_mod_tx.
module tb_adpll_mod_tx;
    import adpll_mod_tx_pkg::*;

    logic                    clk;
    logic                    rst;
    logic                    valid;
    logic [ADPLL_ADDR_W-1:0] address;
    logic [31:0]             wdata;
    logic                    wstrb;
    logic [31:0]             rdata;
    logic                    ready;
    logic                    data_mod;
    logic                    tx_busy;

    int unsigned errors = 0;
    int unsigned checks = 0;

    adpll_mod_tx #(
        .FIFO_AW (3),
        .DIV_W   (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .address  (address),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .rdata    (rdata),
        .ready    (ready),
        .data_mod (data_mod),
        .tx_busy  (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [ADPLL_ADDR_W-1:0] a, input logic [31:0] d);
        valid   = 1'b1;
        wstrb   = 1'b1;
        address = a;
        wdata   = d;
        tick();
        valid   = 1'b0;
        wstrb   = 1'b0;
    endtask

    task automatic cpu_read_check(input string tag, input logic [ADPLL_ADDR_W-1:0] a,
                                  input logic [31:0] exp);
        address = a;
        #1;
        check(tag, rdata, exp);
    endtask

    initial begin
        logic [7:0] b;
        rst     = 1'b1;
        valid   = 1'b0;
        wstrb   = 1'b0;
        address = '0;
        wdata   = '0;
        tick();
        tick();
        // Reset state
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_data_mod", 32'(data_mod), 32'd0);
        check("rst_busy", 32'(tx_busy), 32'd0);
        rst = 1'b0;
        tick();
        cpu_read_check("rst_status", MOD_STATUS, 32'h0000_0004);
        cpu_read_check("rst_bitdiv", MOD_BIT_DIV, 32'd31);
        cpu_read_check("rst_ctrl", MOD_CTRL, 32'd0);

        // Test 1: BIT_DIV=3, LSB first, 0xA5
        cpu_write(MOD_BIT_DIV, 32'd3);
        check("ready_after_write", 32'(ready), 32'd1);
        cpu_read_check("bitdiv_rb", MOD_BIT_DIV, 32'd3);
        cpu_write(MOD_TX_DATA, 32'h0000_00A5);
        cpu_write(MOD_CTRL, 32'h1);
        check("ready_drop", 32'(ready), 32'd1);
        tick();
        check("ready_idle", 32'(ready), 32'd0);
        b = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) begin
                check($sformatf("t1_bit%0d_%0d", i, j), 32'(data_mod), 32'(b[i]));
                check("t1_busy", 32'(tx_busy), 32'd1);
                tick();
            end
        end
        for (int j = 0; j < 4; j++) begin
            check($sformatf("t1_stop%0d", j), 32'(data_mod), 32'd0);
            check("t1_stop_busy", 32'(tx_busy), 32'd1);
            tick();
        end
        check("t1_busy_fall", 32'(tx_busy), 32'd0);

        // Test 2: 0xFF then 0x00 back-to-back, BIT_DIV=0
        cpu_write(MOD_BIT_DIV, 32'd0);
        cpu_write(MOD_TX_DATA, 32'h0000_00FF);
        cpu_write(MOD_TX_DATA, 32'h0000_0000);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t2_bit%0d", i), 32'(data_mod), (i < 8) ? 32'd1 : 32'd0);
            check("t2_busy", 32'(tx_busy), 32'd1);
            tick();
        end
        check("t2_stop_busy", 32'(tx_busy), 32'd1);
        tick();
        check("t2_idle_busy", 32'(tx_busy), 32'd0);

        // Test 3: MSB first, idle level 1, 0x01
        cpu_write(MOD_CTRL, 32'h7);
        tick();
        check("t3_idle_hi", 32'(data_mod), 32'd1);
        cpu_write(MOD_TX_DATA, 32'h0000_0001);
        check("t3_idle_pre", 32'(data_mod), 32'd1);
        tick();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_bit%0d", i), 32'(data_mod), (i == 7) ? 32'd1 : 32'd0);
            tick();
        end
        check("t3_stop_lvl", 32'(data_mod), 32'd1);
        check("t3_stop_busy", 32'(tx_busy), 32'd1);
        tick();
        check("t3_back_idle", 32'(data_mod), 32'd1);
        check("t3_busy_fall", 32'(tx_busy), 32'd0);

        // Test 4: overflow with en=0
        cpu_write(MOD_CTRL, 32'h0);
        for (int i = 0; i < 9; i++) cpu_write(MOD_TX_DATA, 32'h10 + 32'(i));
        cpu_read_check("t4_status_ovf", MOD_STATUS, 32'h0000_008A);
        cpu_write(MOD_STATUS, 32'h8);
        cpu_read_check("t4_status_clr", MOD_STATUS, 32'h0000_0082);

        // Test 5: abort after third bit, idle level 1
        cpu_write(MOD_CTRL, 32'h5);
        tick();
        check("t5_bit0", 32'(data_mod), 32'd0);
        check("t5_busy", 32'(tx_busy), 32'd1);
        tick();
        check("t5_bit1", 32'(data_mod), 32'd0);
        tick();
        check("t5_bit2", 32'(data_mod), 32'd0);
        cpu_write(MOD_CTRL, 32'h4);
        check("t5_bit3", 32'(data_mod), 32'd0);
        tick();
        check("t5_abort_lvl", 32'(data_mod), 32'd1);
        check("t5_abort_busy", 32'(tx_busy), 32'd0);
        cpu_read_check("t5_status", MOD_STATUS, 32'h0000_0070);

        // Flush with data queued
        cpu_write(MOD_CTRL, 32'hC);
        cpu_read_check("flush_status", MOD_STATUS, 32'h0000_0004);
        cpu_read_check("flush_ctrl_rb", MOD_CTRL, 32'h0000_0004);

        // Test 6: reset during SHIFT, unmapped read
        cpu_write(MOD_TX_DATA, 32'h0000_0011);
        cpu_write(MOD_CTRL, 32'h5);
        tick();
        check("t6_bit0", 32'(data_mod), 32'd1);
        check("t6_busy", 32'(tx_busy), 32'd1);
        rst = 1'b1;
        tick();
        check("t6_rst_data", 32'(data_mod), 32'd0);
        check("t6_rst_busy", 32'(tx_busy), 32'd0);
        check("t6_rst_ready", 32'(ready), 32'd0);
        cpu_read_check("t6_rst_status", MOD_STATUS, 32'h0000_0004);
        cpu_read_check("t6_rst_ctrl", MOD_CTRL, 32'd0);
        cpu_read_check("t6_rst_bitdiv", MOD_BIT_DIV, 32'd31);
        rst = 1'b0;
        tick();
        cpu_read_check("t6_unmapped", 8'hF0, 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
